// File: rtl/mm_reg_bank.sv
// mm_reg_bank: parametrised memory-mapped register bank on the data-memory path.
// Decodes a 32-bit byte address against BASE_ADDR / N_REGS (4-byte stride),
// performs byte-enabled writes and registered reads, and returns a one-cycle
// response with an error flag for unmapped or misaligned accesses.
//
// Optional feature (macro MM_REG_BANK_WRCNT_EN): a read-only, saturating
// write-hit counter mapped at BASE_ADDR + 4*N_REGS. Without the macro that
// address is unmapped and no counter logic exists.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   req_valid     access request this cycle
//   req_we        1 = write, 0 = read
//   req_addr      byte address
//   req_wdata     write data
//   req_be        byte enables, bit i -> lane [8i+7:8i]
//   resp_valid    response for the previous cycle's request
//   resp_rdata    read data (0 for writes and errors)
//   resp_err      previous request was unmapped or misaligned
//   reg_out       flat register contents, register k at [32k+31:32k]
//   reg_wr_pulse  one-cycle pulse per register after it is written
module mm_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int unsigned N_REGS    = 5,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [N_REGS*32-1:0]  reg_out,
  output logic [N_REGS-1:0]     reg_wr_pulse
);

  localparam int unsigned IDX_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  // Bounds carried in 33 bits so a bank at the top of the map cannot wrap.
  localparam logic [32:0] BASE_X  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_X = BASE_X + 33'(4 * N_REGS);

  logic [31:0]       regs [N_REGS];
  logic [32:0]       addr_x_c;
  logic [31:0]       offset_c;
  logic              aligned_c;
  logic              reg_hit_c;
  logic [IDX_W-1:0]  idx_c;
  logic              wr_hit_c;
  logic [N_REGS-1:0] wr_sel_c;
  logic [31:0]       rd_data_c;
  logic [31:0]       rdata_c;
  logic              err_c;

  // Address decode; the index is only ever consumed when reg_hit_c is set.
  assign addr_x_c  = {1'b0, req_addr};
  assign offset_c  = req_addr - BASE_ADDR;
  assign aligned_c = (req_addr[1:0] == 2'b00);
  assign reg_hit_c = aligned_c && (addr_x_c >= BASE_X) && (addr_x_c < LIMIT_X);
  assign idx_c     = IDX_W'(offset_c >> 2);
  assign wr_hit_c  = req_valid && req_we && reg_hit_c;

  // One-hot write select per register.
  always_comb begin
    wr_sel_c = '0;
    for (int k = 0; k < int'(N_REGS); k++) begin
      if (wr_hit_c && (idx_c == IDX_W'(k))) wr_sel_c[k] = 1'b1;
    end
  end

  // Read mux over the pre-edge register contents.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(N_REGS); k++) begin
      if (idx_c == IDX_W'(k)) rd_data_c = regs[k];
    end
  end

`ifdef MM_REG_BANK_WRCNT_EN
  logic        cnt_hit_c;
  logic [31:0] wr_cnt;

  assign cnt_hit_c = aligned_c && (addr_x_c == LIMIT_X);

  // Saturating count of accepted write hits on the data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
    end else if (wr_hit_c && (wr_cnt != 32'hFFFF_FFFF)) begin
      wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

  // Next response payload; misses always zero the data.
  always_comb begin
    err_c   = 1'b0;
    rdata_c = '0;
    if (req_valid) begin
      if (reg_hit_c) begin
        if (!req_we) rdata_c = rd_data_c;
      end
`ifdef MM_REG_BANK_WRCNT_EN
      else if (cnt_hit_c) begin
        if (req_we) err_c = 1'b1;
        else        rdata_c = wr_cnt;
      end
`endif
      else begin
        err_c = 1'b1;
      end
    end
  end

  // Register storage with per-lane write enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(N_REGS); k++) regs[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < int'(N_REGS); k++) begin
        if (wr_sel_c[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be[b]) regs[k][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Response and write-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      reg_wr_pulse <= '0;
    end else begin
      resp_valid   <= req_valid;
      resp_err     <= err_c;
      resp_rdata   <= rdata_c;
      reg_wr_pulse <= wr_sel_c;
    end
  end

  // Export storage directly.
  for (genvar g = 0; g < int'(N_REGS); g++) begin : g_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule
